frame_mode_ctrl: RTL

Controls the processing-option select for the image processor output mux and the skin-center overlay select.
- Takes asynchronous switch inputs and synchronizes and debounces them.
- Commits a new mode only at a frame boundary, so no frame ever mixes two pipelines.
- After each switch, asserts a blanking flag for a programmable number of frames to hide pipeline-latency transients.
- Sits between the board switches and the image processor's mode/overlay select inputs.

---
 rtl/image_proc_pkg.sv | 38 +++
 rtl/sw_debounce.sv | 56 +++++
 rtl/frame_mode_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/image_proc_pkg.sv
// Shared types and constants for the image processor mode/overlay control path.
// Holds the mode FSM encoding, bus widths and the mode code table.
package image_proc_pkg;

    localparam int MODE_W = 4;
    localparam int SEL_W  = 2;

    localparam logic [MODE_W-1:0] MODE_PASS  = 4'd0;
    localparam logic [MODE_W-1:0] MODE_YCBCR = 4'd1;
    localparam logic [MODE_W-1:0] MODE_GRAY  = 4'd2;
    localparam logic [MODE_W-1:0] MODE_SKIN  = 4'd3;
    localparam logic [MODE_W-1:0] MODE_LBP   = 4'd4;
    localparam logic [MODE_W-1:0] MODE_BLACK = 4'd7;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        BLANK   = 2'd2
    } mode_state_e;

    typedef struct packed {
        logic [SEL_W-1:0]  sel;
        logic [MODE_W-1:0] mode;
    } sel_mode_t;

    function automatic sel_mode_t clamp_req(
        input sel_mode_t         r,
        input logic [MODE_W-1:0] max_mode
    );
        sel_mode_t c;
        c = r;
        if (r.mode > max_mode) begin
            c.mode = max_mode;
        end
        return c;
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchronizer plus stability counter for a bus of board switches.
// The output only follows the input after it has held still for DEBOUNCE_CYCLES.
module sw_debounce #(
    parameter int W               = 6,
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [W-1:0]  sync1_q, sync1_d;
    logic [W-1:0]  sync2_q, sync2_d;
    logic [W-1:0]  cand_q, cand_d;
    logic [W-1:0]  stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d  = din;
        sync2_d  = sync1_q;
        cand_d   = sync2_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (sync2_q != cand_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            // counter saturates here; candidate is now trusted
            stable_d = cand_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            cand_q   <= '0;
            stable_q <= '0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            cand_q   <= cand_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign dout = stable_q;

endmodule

// File: rtl/frame_mode_ctrl.sv
// Frame-aligned mode/overlay select with post-switch blanking.
// IMAGE_PROC_AUTO_CYCLE_EN adds iAuto and AUTO_FRAMES for unattended mode cycling.
module frame_mode_ctrl
    import image_proc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 65536,
    parameter int BLANK_FRAMES    = 1,
    parameter int MAX_MODE        = 7
`ifdef IMAGE_PROC_AUTO_CYCLE_EN
    ,
    parameter int AUTO_FRAMES     = 60
`endif
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic [MODE_W-1:0] iModeReq,
    input  logic [SEL_W-1:0]  iSelReq,
    input  logic              iFrameValid,
`ifdef IMAGE_PROC_AUTO_CYCLE_EN
    input  logic              iAuto,
`endif
    output logic [MODE_W-1:0] oMode,
    output logic [SEL_W-1:0]  oSel,
    output logic              oBlank,
    output logic              oBusy
);

    localparam logic [MODE_W-1:0] MAX_M = MODE_W'(MAX_MODE);
    localparam int FCW = (BLANK_FRAMES > 0) ? $clog2(BLANK_FRAMES + 1) : 1;
    localparam logic [FCW-1:0] FC_LOAD = FCW'(BLANK_FRAMES);

    mode_state_e state_q, state_d;
    sel_mode_t   cur_q, cur_d;
    sel_mode_t   pend_q, pend_d;
    logic [FCW-1:0] fcnt_q, fcnt_d;

    logic fv1_q, fv2_q, fv3_q;
    logic fend_q, fend_d;

    logic [SEL_W+MODE_W-1:0] sw_raw;
    sel_mode_t sw_req;
    sel_mode_t target;

    sw_debounce #(
        .W               (SEL_W + MODE_W),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_sw_debounce (
        .clk  (iClk),
        .rst  (iRst),
        .din  ({iSelReq, iModeReq}),
        .dout (sw_raw)
    );

    assign sw_req = clamp_req(sw_raw, MAX_M);

    // Frame end is the registered falling edge of the synchronized frame-valid
    assign fend_d = fv3_q & ~fv2_q;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            fv1_q  <= 1'b0;
            fv2_q  <= 1'b0;
            fv3_q  <= 1'b0;
            fend_q <= 1'b0;
        end else begin
            fv1_q  <= iFrameValid;
            fv2_q  <= fv1_q;
            fv3_q  <= fv2_q;
            fend_q <= fend_d;
        end
    end

`ifdef IMAGE_PROC_AUTO_CYCLE_EN
    localparam int AW = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
    localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_FRAMES - 1);

    logic [AW-1:0] acnt_q, acnt_d;
    sel_mode_t     areq_q, areq_d;

    assign target = iAuto ? areq_q : sw_req;

    always_comb begin
        acnt_d = acnt_q;
        areq_d = areq_q;
        if (!iAuto) begin
            acnt_d = '0;
            areq_d = cur_d;
        end else if (fend_q) begin
            if (acnt_q >= AUTO_LAST) begin
                acnt_d      = '0;
                areq_d.sel  = cur_d.sel;
                areq_d.mode = (cur_d.mode >= MAX_M) ? '0
                            : cur_d.mode + MODE_W'(1);
            end else begin
                acnt_d = acnt_q + AW'(1);
            end
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            acnt_q <= '0;
            areq_q <= '0;
        end else begin
            acnt_q <= acnt_d;
            areq_q <= areq_d;
        end
    end
`else
    assign target = sw_req;
`endif

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= IDLE;
            cur_q   <= '{sel: '0, mode: MODE_PASS};
            pend_q  <= '0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            pend_q  <= pend_d;
            fcnt_q  <= fcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        pend_d  = pend_q;
        fcnt_d  = fcnt_q;
        unique case (state_q)
            IDLE: begin
                if (target != cur_q) begin
                    pend_d  = target;
                    state_d = PENDING;
                end
            end
            PENDING: begin
                pend_d = target;
                if (fend_q) begin
                    // commit the value held before this cycle's update
                    cur_d = pend_q;
                    if (BLANK_FRAMES > 0) begin
                        fcnt_d  = FC_LOAD;
                        state_d = BLANK;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (target == cur_q) begin
                    state_d = IDLE;
                end
            end
            BLANK: begin
                if (fend_q) begin
                    if (fcnt_q <= FCW'(1)) begin
                        fcnt_d  = '0;
                        state_d = IDLE;
                    end else begin
                        fcnt_d = fcnt_q - FCW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        oMode  = cur_q.mode;
        oSel   = cur_q.sel;
        oBlank = (state_q == BLANK);
        oBusy  = (state_q != IDLE);
    end

endmodule
